sap_control_sequencer: RTL
==========================

Name: sap_control_sequencer

Overview:
- Microcoded control sequencer for the 8-bit bus computer. Drives the control signals of the program counter, MAR, RAM, instruction register, A/B registers, ALU, output register and halt.
- Runs a variable-length T-state counter and decodes the IR opcode into a one-hot-per-signal control word.
- Holds an internal flags register loaded from the ALU zero/carry outputs, which is used for conditional jumps.

Parameters:
OP_WIDTH, 4, opcode width (IR upper nibble)
STEP_WIDTH, 3, T-state counter width (steps T0..T4 used)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge
run  input  1  1 = sequence; 0 = freeze step and flags, force ctrl to 0
opcode  input  4  IR[7:4]
alu_zf  input  1  ALU zero flag (combinational)
alu_cf  input  1  ALU carry flag (combinational)
ctrl  output  16  control word, bit map in Behaviour
step  output  3  current T-state, for debug/display
zf_q  output  1  latched zero flag
cf_q  output  1  latched carry flag
halted  output  1  halt latch

Behaviour:
- ctrl bit map:
  - 15 hlt, 14 mi, 13 ri, 12 ro, 11 io, 10 ii, 9 ai, 8 ao
  - 7 eo, 6 su, 5 bi, 4 oi, 3 ce, 2 co, 1 j, 0 fi
- Reset (rst_n=0 at edge): step=0, zf_q=0, cf_q=0, halted=0. ctrl then decodes to T0 fetch (co|mi). This applies mid-instruction: any step is abandoned.
- ctrl is combinational from step, opcode, zf_q, cf_q, halted and run. It is stable for the whole cycle; consumers act on the next rising edge.
- run=0 or halted=1: ctrl=0 except hlt=1 when halted. step, zf_q and cf_q hold.
- Fetch, all opcodes: T0 co mi; T1 ro ii ce.
- Execute (T2 onward):
  - 0001 LDA: T2 io mi; T3 ro ai.
  - 0010 ADD: T2 io mi; T3 ro bi; T4 eo ai fi.
  - 0011 SUB: same as ADD with su also set in T4.
  - 0100 STA: T2 io mi; T3 ao ri.
  - 0101 LDI: T2 io ai.
  - 0110 JMP: T2 io j.
  - 0111 JC: T2 io j if cf_q=1, else ctrl=0. Length is 3 either way.
  - 1000 JZ: as JC using zf_q.
  - 1110 OUT: T2 ao oi.
  - 1111 HLT: T2 hlt. halted is set at the end of T2 and stays set until reset.
  - 0000 NOP and all undefined opcodes: no execute steps.
- Step advance, when run=1 and halted=0: step increments each clock. When the current step is the last step of the decoded instruction, step returns to 0 on the next edge.
- Instruction lengths: NOP/undefined 2; LDI/JMP/JC/JZ/OUT/HLT 3; LDA/STA 4; ADD/SUB 5.
- Step never exceeds 4. Any out-of-range step value forces step to 0 on the next edge.
- Flags: when fi=1 in the current ctrl, zf_q<=alu_zf and cf_q<=alu_cf on that edge. Otherwise the flags hold.
- A conditional jump uses the flags latched by an earlier instruction, never live ALU flags.
- Opcode is sampled combinationally at every step. It is only meaningful from T2 onward (IR is loaded at the end of T1); in T0/T1 ctrl ignores opcode.
- Simultaneous rst_n=0 and run=0: reset wins.

Test Plan:
- Reset then run=1, opcode=0001: ctrl sequence over 4 cycles 0x4004, 0x1408, 0x4800, 0x1200 -> step 0,1,2,3, then 0.
- opcode=0011, alu_zf=1, alu_cf=1: T4 ctrl=0x02C1 (eo|ai|su|fi); after edge zf_q=1, cf_q=1; step returns to 0.
- JC with cf_q=0: T2 ctrl=0x0000 and step returns to 0. JC with cf_q=1: T2 ctrl=0x0802.
- opcode=1111: T2 ctrl=0x8000, then halted=1 and ctrl stays 0x8000 for 10+ cycles regardless of opcode/run; rst_n=0 clears halted, and step=0 with ctrl=0x4004.
- ADD mid-sequence (step=3): run=0 for 3 cycles -> ctrl=0, step holds 3. run=1 resumes at T3 with ctrl=0x1020.
- rst_n=0 asserted at step=4 of SUB with fi pending: next edge step=0, flags=0, flags not loaded.

Source files
------------

// File: rtl/sap_control_sequencer.sv
// Microcoded control sequencer for the 8-bit bus computer: T-state counter,
// opcode decode to a 16-bit control word, latched ALU flags and halt latch.
module sap_control_sequencer #(
  parameter int OP_WIDTH   = 4,
  parameter int STEP_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [OP_WIDTH-1:0]   opcode,
  input  logic                  alu_zf,
  input  logic                  alu_cf,
  output logic [15:0]           ctrl,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  zf_q,
  output logic                  cf_q,
  output logic                  halted
);

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

  localparam logic [OP_WIDTH-1:0] OP_LDA = OP_WIDTH'(4'b0001);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(4'b0010);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(4'b0011);
  localparam logic [OP_WIDTH-1:0] OP_STA = OP_WIDTH'(4'b0100);
  localparam logic [OP_WIDTH-1:0] OP_LDI = OP_WIDTH'(4'b0101);
  localparam logic [OP_WIDTH-1:0] OP_JMP = OP_WIDTH'(4'b0110);
  localparam logic [OP_WIDTH-1:0] OP_JC  = OP_WIDTH'(4'b0111);
  localparam logic [OP_WIDTH-1:0] OP_JZ  = OP_WIDTH'(4'b1000);
  localparam logic [OP_WIDTH-1:0] OP_OUT = OP_WIDTH'(4'b1110);
  localparam logic [OP_WIDTH-1:0] OP_HLT = OP_WIDTH'(4'b1111);

  typedef enum logic [STEP_WIDTH-1:0] {
    T0 = STEP_WIDTH'(0), T1 = STEP_WIDTH'(1), T2 = STEP_WIDTH'(2),
    T3 = STEP_WIDTH'(3), T4 = STEP_WIDTH'(4)
  } tstate_e;

  tstate_e st;
  tstate_e last_st;

  assign step = st;

  always_comb begin
    last_st = T1;
    case (opcode)
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_st = T2;
      OP_LDA, OP_STA:                               last_st = T3;
      OP_ADD, OP_SUB:                               last_st = T4;
      default:                                      last_st = T1;
    endcase
  end

  always_comb begin
    ctrl = '0;
    if (halted) begin
      ctrl = HLT;
    end else if (run) begin
      case (st)
        T0: ctrl = CO | MI;
        T1: ctrl = RO | II | CE;
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = IO | MI;
            OP_LDI: ctrl = IO | AI;
            OP_JMP: ctrl = IO | J;
            OP_JC:  ctrl = cf_q ? (IO | J) : '0;
            OP_JZ:  ctrl = zf_q ? (IO | J) : '0;
            OP_OUT: ctrl = AO | OI;
            OP_HLT: ctrl = HLT;
            default: ctrl = '0;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA:         ctrl = RO | AI;
            OP_ADD, OP_SUB: ctrl = RO | BI;
            OP_STA:         ctrl = AO | RI;
            default:        ctrl = '0;
          endcase
        end
        T4: begin
          case (opcode)
            OP_ADD:  ctrl = EO | AI | FI;
            OP_SUB:  ctrl = EO | AI | SU | FI;
            default: ctrl = '0;
          endcase
        end
        default: ctrl = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= T0;
      zf_q   <= 1'b0;
      cf_q   <= 1'b0;
      halted <= 1'b0;
    end else if (run && !halted) begin
      if (ctrl[0]) begin
        zf_q <= alu_zf;
        cf_q <= alu_cf;
      end
      if (ctrl[15]) halted <= 1'b1;
      // out-of-range encodings fall into the wrap branch and recover to T0
      if (st == last_st || st > T4) st <= T0;
      else                          st <= tstate_e'(st + STEP_WIDTH'(1));
    end
  end

endmodule
